// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiplication sequencer.
//   state_e : sequencer states (double-and-add walk over the scalar)
//   OP_DBL / OP_ADD : values driven on op_dbl for the point unit
package ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOOP,
    DBL,
    WDBL,
    ADD,
    WADD,
    FIN
  } state_e;

  localparam logic OP_DBL = 1'b1;
  localparam logic OP_ADD = 1'b0;

endpackage

// File: rtl/point_op_mux.sv
// Operand selector for the point-operation request.
//   en_i        : operands are driven only while a request is outstanding
//   dbl_i       : 1 = double R (both operands R), 0 = add R + P
//   rx_i/ry_i   : accumulator R
//   bx_i/by_i   : captured base point P
//   x1_o..y2_o  : operands to the point unit (zero when not enabled)
module point_op_mux #(
  parameter int N = 231
) (
  input  logic         en_i,
  input  logic         dbl_i,
  input  logic [N-1:0] rx_i,
  input  logic [N-1:0] ry_i,
  input  logic [N-1:0] bx_i,
  input  logic [N-1:0] by_i,
  output logic [N-1:0] x1_o,
  output logic [N-1:0] y1_o,
  output logic [N-1:0] x2_o,
  output logic [N-1:0] y2_o
);

  always_comb begin
    x1_o = '0;
    y1_o = '0;
    x2_o = '0;
    y2_o = '0;
    if (en_i) begin
      x1_o = rx_i;
      y1_o = ry_i;
      x2_o = dbl_i ? rx_i : bx_i;
      y2_o = dbl_i ? ry_i : by_i;
    end
  end

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer computing Q = k*P. Initiator on a
// req/ack point-operation interface; infinity travels as an explicit flag.
//   clk, reset (async, active low)
//   start, k, p, px, py       : command (k, P captured on accepted start)
//   busy, done, qx, qy, q_inf : status / result (q held until next done)
//   op_req, op_dbl, op_x1..op_y2 : request to point unit (operands stable
//                                  from op_req until op_ack)
//   op_ack, op_rx, op_ry, op_rinf : response, valid only in the ack cycle
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int N = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] k,
  input  logic [N-1:0] p,
  input  logic [N-1:0] px,
  input  logic [N-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] qx,
  output logic [N-1:0] qy,
  output logic         q_inf,
  output logic         op_req,
  output logic         op_dbl,
  output logic [N-1:0] op_x1,
  output logic [N-1:0] op_y1,
  output logic [N-1:0] op_x2,
  output logic [N-1:0] op_y2,
  input  logic         op_ack,
  input  logic [N-1:0] op_rx,
  input  logic [N-1:0] op_ry,
  input  logic         op_rinf
);

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   kreg_q, kreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic           rinf_q, rinf_d;
  logic [N-1:0]   bx_q, bx_d, by_q, by_d;
  logic           bit_q, bit_d;
  logic [N-1:0]   qx_q, qx_d, qy_q, qy_d;
  logic           qinf_q, qinf_d;
  logic           fin_go;

  // The prime is consumed by the point unit; this block only sequences.
  logic unused_p;
  assign unused_p = ^p;

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rinf_d  = rinf_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bit_d   = bit_q;
    fin_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          kreg_d  = k;
          cnt_d   = CW'(N);
          bx_d    = px;
          by_d    = py;
          rinf_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == '0) begin
          fin_go = 1'b1;
        end else begin
          kreg_d = kreg_q << 1;
          cnt_d  = cnt_q - CW'(1);
          // Leading one found: R = P without spending a point operation.
          if (kreg_q[N-1]) begin
            rx_d    = bx_q;
            ry_d    = by_q;
            rinf_d  = 1'b0;
            state_d = LOOP;
          end
        end
      end
      LOOP: begin
        if (cnt_q == '0) begin
          fin_go = 1'b1;
        end else begin
          bit_d   = kreg_q[N-1];
          kreg_d  = kreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
          state_d = DBL;
        end
      end
      DBL: begin
        // 2*O = O, so an infinite accumulator skips the request.
        if (rinf_q) state_d = bit_q ? ADD : LOOP;
        else        state_d = WDBL;
      end
      WDBL: begin
        if (op_ack) begin
          rx_d    = op_rx;
          ry_d    = op_ry;
          rinf_d  = op_rinf;
          state_d = bit_q ? ADD : LOOP;
        end
      end
      ADD: begin
        // O + P = P, again without a request.
        if (rinf_q) begin
          rx_d    = bx_q;
          ry_d    = by_q;
          rinf_d  = 1'b0;
          state_d = LOOP;
        end else begin
          state_d = WADD;
        end
      end
      WADD: begin
        if (op_ack) begin
          rx_d    = op_rx;
          ry_d    = op_ry;
          rinf_d  = op_rinf;
          state_d = LOOP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin_go) state_d = FIN;
  end

  // Result registers load on entry to FIN so they are valid with done.
  always_comb begin
    qx_d   = qx_q;
    qy_d   = qy_q;
    qinf_d = qinf_q;
    if (fin_go) begin
      qx_d   = rx_q;
      qy_d   = ry_q;
      qinf_d = rinf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b1;
      bx_q    <= '0;
      by_q    <= '0;
      bit_q   <= 1'b0;
      qx_q    <= '0;
      qy_q    <= '0;
      qinf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rinf_q  <= rinf_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bit_q   <= bit_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qinf_q  <= qinf_d;
    end
  end

  // FIN is the done cycle and is already not busy, so busy falls with done.
  logic op_phase, op_en, dbl_sel;
  assign op_phase = (state_q == DBL) || (state_q == WDBL) ||
                    (state_q == ADD) || (state_q == WADD);
  assign op_en    = op_phase && !rinf_q;
  assign dbl_sel  = (state_q == DBL) || (state_q == WDBL);

  assign busy   = (state_q != IDLE) && (state_q != FIN);
  assign done   = (state_q == FIN);
  assign op_req = ((state_q == DBL) || (state_q == ADD)) && !rinf_q;
  assign op_dbl = op_en ? dbl_sel : OP_ADD;
  assign qx     = qx_q;
  assign qy     = qy_q;
  assign q_inf  = qinf_q;

  point_op_mux #(.N(N)) u_mux (
    .en_i  (op_en),
    .dbl_i (dbl_sel),
    .rx_i  (rx_q),
    .ry_i  (ry_q),
    .bx_i  (bx_q),
    .by_i  (by_q),
    .x1_o  (op_x1),
    .y1_o  (op_y1),
    .x2_o  (op_x2),
    .y2_o  (op_y2)
  );

endmodule

// File: doc/scalar_mult_ctrl.md
# scalar_mult_ctrl

Left-to-right double-and-add sequencer for ECC scalar multiplication Q = k·P over GF(p). It is the initiator on the point-operation interface: it issues add/double requests to an external point-operation unit (the responder, wrapping point addition/doubling) and collects the results over a req/ack handshake. The block sits between the top-level scalar-multiplication command interface and the point arithmetic datapath. Infinity is carried as an explicit flag, never encoded in coordinate values.

## Interface
- N, default 231: field and scalar width in bits.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- k  input  N  scalar; captured when start is accepted.
- p  input  N  field prime; must be held stable while busy.
- px, py  input  N  base point P; captured when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the result is valid.
- qx, qy  output  N  result coordinates; held until the next done.
- q_inf  output  1  result is the point at infinity.
- op_req  output  1  one-cycle request pulse to the point unit.
- op_dbl  output  1  1 = double (x1, y1), 0 = add (x1, y1) + (x2, y2).
- op_x1, op_y1, op_x2, op_y2  output  N  operands; stable from op_req until op_ack.
- op_ack  input  1  one-cycle completion pulse from the point unit.
- op_rx, op_ry  input  N  result coordinates; valid only in the op_ack cycle.
- op_rinf  input  1  result is infinity; valid only in the op_ack cycle.

## Operation
- Internal state: kreg[N-1:0], cnt (0..N), accumulator R = (rx, ry, rinf), and captured base point (bx, by).
- IDLE: on start, load kreg←k, cnt←N, (bx, by)←(px, py), rinf←1, then go to SCAN. A start while busy is ignored.
- SCAN:
  - If cnt = 0, go to FIN with infinity (k = 0).
  - Otherwise shift kreg left and decrement cnt.
  - If the old kreg[N-1] = 1, set R←P, rinf←0, and go to LOOP; otherwise stay in SCAN.
- LOOP: if cnt = 0, go to FIN. Otherwise latch bit←kreg[N-1], shift kreg, decrement cnt, and go to DBL.
- DBL:
  - If rinf = 1, skip the request and go directly to the add decision (2·O = O).
  - Otherwise pulse op_req with op_dbl=1, op_x1/op_y1 = R and op_x2/op_y2 = R, then go to WDBL.
- WDBL: on op_ack, R←(op_rx, op_ry, op_rinf), then go to the add decision.
- Add decision: if bit = 0, go to LOOP; otherwise go to ADD.
- ADD:
  - If rinf = 1, set R←P, rinf←0, and go to LOOP with no request.
  - Otherwise pulse op_req with op_dbl=0, operand 1 = R and operand 2 = P, then go to WADD.
- WADD: on op_ack, load R from the op result and go to LOOP.
- FIN: qx←rx, qy←ry, q_inf←rinf, pulse done, then return to IDLE.
- op_ack outside WDBL/WADD is ignored. The point unit handles x1 = x2 and returns op_rinf as needed.

## Timing
- Reset (asynchronous, active-low) forces:
  - State IDLE.
  - busy, done, op_req, op_dbl, q_inf = 0.
  - qx, qy, and all op operands = 0.
  - rinf = 1.
- Reset mid-operation abandons the operation silently. A late op_ack after reset is ignored.
- Cycle counts:
  - Start accepted at edge t; busy = 1 from t+1.
  - SCAN costs one cycle per bit examined.
  - LOOP, DBL, ADD, and FIN cost one cycle each.
  - Each WDBL/WADD waits for the ack, with a minimum of 1 cycle.
- With a zero-latency (next-cycle) responder and MSB index m, the op count is m doubles plus popcount(k)−1 adds.
- done is asserted in the same cycle busy falls. start in the done cycle is ignored; it is accepted from the next cycle.

## Structure
- Shared package (ecc_pkg): state enum (IDLE, SCAN, LOOP, DBL, WDBL, ADD, WADD, FIN) and an op-code constant for double/add.
- Single module. Optional sub-module point_op_mux selects operands for the double/add cases.
- cnt width is $clog2(N+1).

## Test plan
Bench uses N=8 and a behavioural point unit for y² = x³+2x+2 mod 17 (p=17, P=(5,1), order 19) with programmable ack latency of 1–5 cycles.
- k=0 → done after 9 busy cycles; q_inf=1; zero op_req.
- k=1 → q=(5,1), q_inf=0; zero op_req.
- k=2 → one double request; q=(6,3).
- k=9 (1001b) → 3 doubles + 1 add, issued in the order D, D, D, A; q=(7,6).
- k=19 (10011b) → 4 doubles + 2 adds; final add of 18P+P returns op_rinf, so q_inf=1. Repeat with random ack latencies for identical results.
- Reset asserted while in WDBL, followed by an ack pulse → stays IDLE, all outputs zero. start asserted while busy → ignored, and the running result is unchanged.
